// File: rtl/reconstruction.sv
// -----------------------------------------------------------------------------
// reconstruction
//
// Adds an 8-lane row of signed residuals back onto the matching best-candidate
// prediction row, clips each lane to the unsigned pixel range and registers the
// reconstructed row.
//
// Pipeline: stage 1 latches the inputs; stage 2 does the add/clip and
// registers the results. Inputs sampled at edge N are on out_* after edge N+1.
//
// Ports
//   clock                       rising-edge clock
//   reset                       asynchronous, active-high
//   enable                      input row valid this cycle
//   flush                       synchronous block restart (row counter and
//                               stage-1 valid cleared)
//   residual_0..7               signed residuals, DATAWIDTH+1 bits
//   best_candidate_0..7         unsigned predictions, DATAWIDTH bits
//   out_0..7                    reconstructed, clipped pixels
//   valid_out                   out_*/sat_out/row_index updated this cycle
//   sat_out                     bit i set when lane i was clipped
//   row_index                   row number within the block of out_*
//   block_done                  one-cycle pulse with the last row of a block
// -----------------------------------------------------------------------------
module reconstruction #(
    parameter int DATAWIDTH  = 8,
    parameter int BLOCK_ROWS = 8,
    parameter int ROW_WIDTH  = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        flush,
    input  logic signed [DATAWIDTH:0]   residual_0,
    input  logic signed [DATAWIDTH:0]   residual_1,
    input  logic signed [DATAWIDTH:0]   residual_2,
    input  logic signed [DATAWIDTH:0]   residual_3,
    input  logic signed [DATAWIDTH:0]   residual_4,
    input  logic signed [DATAWIDTH:0]   residual_5,
    input  logic signed [DATAWIDTH:0]   residual_6,
    input  logic signed [DATAWIDTH:0]   residual_7,
    input  logic [DATAWIDTH-1:0]        best_candidate_0,
    input  logic [DATAWIDTH-1:0]        best_candidate_1,
    input  logic [DATAWIDTH-1:0]        best_candidate_2,
    input  logic [DATAWIDTH-1:0]        best_candidate_3,
    input  logic [DATAWIDTH-1:0]        best_candidate_4,
    input  logic [DATAWIDTH-1:0]        best_candidate_5,
    input  logic [DATAWIDTH-1:0]        best_candidate_6,
    input  logic [DATAWIDTH-1:0]        best_candidate_7,
    output logic [DATAWIDTH-1:0]        out_0,
    output logic [DATAWIDTH-1:0]        out_1,
    output logic [DATAWIDTH-1:0]        out_2,
    output logic [DATAWIDTH-1:0]        out_3,
    output logic [DATAWIDTH-1:0]        out_4,
    output logic [DATAWIDTH-1:0]        out_5,
    output logic [DATAWIDTH-1:0]        out_6,
    output logic [DATAWIDTH-1:0]        out_7,
    output logic                        valid_out,
    output logic [7:0]                  sat_out,
    output logic [ROW_WIDTH-1:0]        row_index,
    output logic                        block_done
);

    localparam int LANES = 8;
    // Sum width: one bit for the residual sign plus one for carry out of the
    // pixel range, so every candidate+residual combination is representable.
    localparam int SW = DATAWIDTH + 2;
    localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(BLOCK_ROWS - 1);

    // Lane-packed views of the flat port list
    logic [LANES-1:0][DATAWIDTH:0]   res_in;
    logic [LANES-1:0][DATAWIDTH-1:0] cand_in;

    assign res_in[0] = residual_0;
    assign res_in[1] = residual_1;
    assign res_in[2] = residual_2;
    assign res_in[3] = residual_3;
    assign res_in[4] = residual_4;
    assign res_in[5] = residual_5;
    assign res_in[6] = residual_6;
    assign res_in[7] = residual_7;

    assign cand_in[0] = best_candidate_0;
    assign cand_in[1] = best_candidate_1;
    assign cand_in[2] = best_candidate_2;
    assign cand_in[3] = best_candidate_3;
    assign cand_in[4] = best_candidate_4;
    assign cand_in[5] = best_candidate_5;
    assign cand_in[6] = best_candidate_6;
    assign cand_in[7] = best_candidate_7;

    // Stage 1
    logic [LANES-1:0][DATAWIDTH:0]   res_reg;
    logic [LANES-1:0][DATAWIDTH-1:0] cand_reg;
    logic                            s1_valid_reg;

    // Stage 2
    logic [LANES-1:0][DATAWIDTH-1:0] out_reg;
    logic [LANES-1:0]                sat_reg;
    logic [ROW_WIDTH-1:0]            row_index_reg;
    logic [ROW_WIDTH-1:0]            row_cnt_reg;
    logic                            valid_reg;
    logic                            done_reg;

    // Add/clip results feeding stage 2
    logic [LANES-1:0][DATAWIDTH-1:0] pix_next;
    logic [LANES-1:0]                sat_next;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [SW-1:0] sum;
            logic                 clip_low;
            logic                 clip_high;

            // Candidate is zero-extended, residual sign-extended.
            assign sum = $signed({2'b00, cand_reg[gi]})
                       + $signed({res_reg[gi][DATAWIDTH], res_reg[gi]});

            // Negative sums clip to 0; a non-negative sum with the bit just
            // above the pixel range set has exceeded the maximum pixel value.
            assign clip_low  = sum[SW-1];
            assign clip_high = ~sum[SW-1] & sum[DATAWIDTH];

            assign pix_next[gi] = clip_low  ? '0 :
                                  clip_high ? '1 :
                                  sum[DATAWIDTH-1:0];
            assign sat_next[gi] = clip_low | clip_high;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_reg       <= '0;
            cand_reg      <= '0;
            s1_valid_reg  <= 1'b0;
            out_reg       <= '0;
            sat_reg       <= '0;
            row_index_reg <= '0;
            row_cnt_reg   <= '0;
            valid_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            // Stage 1: data loads whenever enabled; a flush only kills the
            // valid, so a row arriving with flush is silently discarded.
            if (enable) begin
                res_reg  <= res_in;
                cand_reg <= cand_in;
            end
            s1_valid_reg <= enable & ~flush;

            // Stage 2: a row already validated in stage 1 still completes on
            // a flush edge, numbered with the pre-flush counter.
            valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_reg       <= pix_next;
                sat_reg       <= sat_next;
                row_index_reg <= row_cnt_reg;
                done_reg      <= (row_cnt_reg == LAST_ROW);
                row_cnt_reg   <= (row_cnt_reg == LAST_ROW) ? '0
                                                           : row_cnt_reg + ROW_WIDTH'(1);
            end else begin
                done_reg <= 1'b0;
            end

            // Flush overrides the counter advance above.
            if (flush) begin
                row_cnt_reg <= '0;
            end
        end
    end

    assign out_0      = out_reg[0];
    assign out_1      = out_reg[1];
    assign out_2      = out_reg[2];
    assign out_3      = out_reg[3];
    assign out_4      = out_reg[4];
    assign out_5      = out_reg[5];
    assign out_6      = out_reg[6];
    assign out_7      = out_reg[7];
    assign valid_out  = valid_reg;
    assign sat_out    = sat_reg;
    assign row_index  = row_index_reg;
    assign block_done = done_reg;

endmodule

// File: tb/tb_reconstruction.sv
// -----------------------------------------------------------------------------
// tb_reconstruction
//
// Self-checking bench for reconstruction. A transaction-level model tracks the
// row accepted at each edge (clipped pixels from integer arithmetic, row number
// from a block-relative count) and the outputs expected after the next edge.
// -----------------------------------------------------------------------------
module tb_reconstruction;

    localparam int DW    = 8;
    localparam int BR    = 8;
    localparam int RW    = 3;
    localparam int LANES = 8;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;
    logic flush  = 1'b0;

    logic signed [DW:0] res_s  [LANES];
    logic [DW-1:0]      cand_s [LANES];

    logic [DW-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic          valid_out;
    logic [7:0]    sat_out;
    logic [RW-1:0] row_index;
    logic          block_done;

    wire [63:0] out_bus = {o7, o6, o5, o4, o3, o2, o1, o0};

    // Model state
    logic [63:0]   exp_bus, pend_bus;
    logic [7:0]    exp_sat, pend_sat;
    logic [RW-1:0] exp_idx, pend_idx;
    bit            exp_valid, exp_done, pend_v;
    int            row_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    reconstruction #(
        .DATAWIDTH (DW),
        .BLOCK_ROWS(BR),
        .ROW_WIDTH (RW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .flush           (flush),
        .residual_0      (res_s[0]),
        .residual_1      (res_s[1]),
        .residual_2      (res_s[2]),
        .residual_3      (res_s[3]),
        .residual_4      (res_s[4]),
        .residual_5      (res_s[5]),
        .residual_6      (res_s[6]),
        .residual_7      (res_s[7]),
        .best_candidate_0(cand_s[0]),
        .best_candidate_1(cand_s[1]),
        .best_candidate_2(cand_s[2]),
        .best_candidate_3(cand_s[3]),
        .best_candidate_4(cand_s[4]),
        .best_candidate_5(cand_s[5]),
        .best_candidate_6(cand_s[6]),
        .best_candidate_7(cand_s[7]),
        .out_0           (o0),
        .out_1           (o1),
        .out_2           (o2),
        .out_3           (o3),
        .out_4           (o4),
        .out_5           (o5),
        .out_6           (o6),
        .out_7           (o7),
        .valid_out       (valid_out),
        .sat_out         (sat_out),
        .row_index       (row_index),
        .block_done      (block_done)
    );

    task automatic model_reset();
        exp_bus   = '0;
        exp_sat   = '0;
        exp_idx   = '0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        pend_bus  = '0;
        pend_sat  = '0;
        pend_idx  = '0;
        pend_v    = 1'b0;
        row_count = 0;
    endtask

    task automatic randomize_row();
        for (int i = 0; i < LANES; i++) begin
            res_s[i]  = 9'($urandom_range(0, 511));
            cand_s[i] = 8'($urandom_range(0, 255));
        end
    endtask

    // Drive one cycle of inputs, advance the model, and return #1 after the edge
    // that produces the outputs the model now expects.
    task automatic drive_cycle(input bit en, input bit fl);
        int s;
        enable = en;
        flush  = fl;
        // Row accepted last edge emerges on this edge; otherwise outputs hold.
        if (pend_v) begin
            exp_valid = 1'b1;
            exp_bus   = pend_bus;
            exp_sat   = pend_sat;
            exp_idx   = pend_idx;
            exp_done  = (int'(pend_idx) == BR - 1);
        end else begin
            exp_valid = 1'b0;
            exp_done  = 1'b0;
        end
        if (fl) row_count = 0;
        pend_v = en && !fl;
        if (pend_v) begin
            for (int i = 0; i < LANES; i++) begin
                s = int'(cand_s[i]) + int'(res_s[i]);
                pend_bus[i*8 +: 8] = (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : 8'(s);
                pend_sat[i]        = (s < 0) || (s > 255);
            end
            pend_idx  = RW'(row_count);
            row_count = (row_count + 1) % BR;
        end
        @(posedge clock);
        #1;
        if (valid_out)
            $display("row idx=%0d out=%h sat=%h done=%b", row_index, out_bus, sat_out, block_done);
    endtask

    task automatic test_reset();
        randomize_row();
        enable = 1'b1;
        reset  = 1'b1;
        #12;
        n_checks++; if (out_bus !== 64'd0) $display("FAIL reset_out got=%h exp=0", out_bus); else n_pass++;
        n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_out); else n_pass++;
        n_checks++; if (sat_out !== 8'h00) $display("FAIL reset_sat got=%h exp=00", sat_out); else n_pass++;
        n_checks++; if (row_index !== '0) $display("FAIL reset_row got=%0d exp=0", row_index); else n_pass++;
        n_checks++; if (block_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", block_done); else n_pass++;
        reset  = 1'b0;
        enable = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            randomize_row();
            drive_cycle(1'b0, 1'b0);
            n_checks++; if (valid_out !== 1'b0) $display("FAIL idle_valid cyc=%0d got=%b exp=0", c, valid_out); else n_pass++;
            n_checks++; if (out_bus !== 64'd0) $display("FAIL idle_out cyc=%0d got=%h exp=0", c, out_bus); else n_pass++;
        end
    endtask

    task automatic test_basic_add();
        logic [63:0] want;
        for (int i = 0; i < LANES; i++) begin
            res_s[i]  = 9'(i - 4);
            cand_s[i] = 8'd100;
            want[i*8 +: 8] = 8'(96 + i);
        end
        drive_cycle(1'b1, 1'b0);
        n_checks++; if (valid_out !== 1'b0) $display("FAIL basic_early_valid got=%b exp=0", valid_out); else n_pass++;
        randomize_row();
        drive_cycle(1'b0, 1'b0);
        n_checks++; if (valid_out !== 1'b1) $display("FAIL basic_valid got=%b exp=1", valid_out); else n_pass++;
        n_checks++; if (out_bus !== want) $display("FAIL basic_out got=%h exp=%h", out_bus, want); else n_pass++;
        n_checks++; if (sat_out !== 8'h00) $display("FAIL basic_sat got=%h exp=00", sat_out); else n_pass++;
        n_checks++; if (row_index !== 3'd0) $display("FAIL basic_row got=%0d exp=0", row_index); else n_pass++;
        drive_cycle(1'b0, 1'b0);
        n_checks++; if (valid_out !== 1'b0) $display("FAIL basic_after_valid got=%b exp=0", valid_out); else n_pass++;
        n_checks++; if (out_bus !== want) $display("FAIL basic_hold got=%h exp=%h", out_bus, want); else n_pass++;
    endtask

    task automatic test_clipping();
        logic [63:0] want;
        for (int i = 0; i < LANES; i++) begin
            cand_s[i] = 8'd128;
            res_s[i]  = 9'sd0;
        end
        cand_s[0] = 8'd10;  res_s[0] = -9'sd50;
        cand_s[1] = 8'd250; res_s[1] = 9'sd20;
        cand_s[2] = 8'd0;   res_s[2] = -9'sd256;
        cand_s[3] = 8'd255; res_s[3] = 9'sd255;
        cand_s[4] = 8'd255; res_s[4] = 9'sd0;
        want = {8'd128, 8'd128, 8'd128, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0};
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0);
        n_checks++; if (valid_out !== 1'b1) $display("FAIL clip_valid got=%b exp=1", valid_out); else n_pass++;
        n_checks++; if (out_bus !== want) $display("FAIL clip_out got=%h exp=%h", out_bus, want); else n_pass++;
        n_checks++; if (sat_out !== 8'h0F) $display("FAIL clip_sat got=%h exp=0f", sat_out); else n_pass++;
        n_checks++; if (row_index !== 3'd1) $display("FAIL clip_row got=%0d exp=1", row_index); else n_pass++;
        n_checks++; if (out_bus !== exp_bus) $display("FAIL clip_model got=%h exp=%h", out_bus, exp_bus); else n_pass++;
    endtask

    task automatic test_streaming();
        int n_valid = 0;
        int n_done  = 0;
        int ord;
        drive_cycle(1'b0, 1'b1);
        for (int c = 0; c < 19; c++) begin
            randomize_row();
            drive_cycle(c < 17, 1'b0);
            n_checks++;
            if (valid_out !== (c >= 1 && c <= 17))
                $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, valid_out, (c >= 1 && c <= 17));
            else n_pass++;
            if (c >= 1 && c <= 17) begin
                ord = c - 1;
                n_valid++;
                if (block_done) n_done++;
                n_checks++; if (row_index !== RW'(ord % BR)) $display("FAIL stream_row ord=%0d got=%0d exp=%0d", ord, row_index, ord % BR); else n_pass++;
                n_checks++; if (block_done !== (ord % BR == BR - 1)) $display("FAIL stream_done ord=%0d got=%b exp=%b", ord, block_done, (ord % BR == BR - 1)); else n_pass++;
                n_checks++; if (out_bus !== exp_bus) $display("FAIL stream_out ord=%0d got=%h exp=%h", ord, out_bus, exp_bus); else n_pass++;
                n_checks++; if (sat_out !== exp_sat) $display("FAIL stream_sat ord=%0d got=%h exp=%h", ord, sat_out, exp_sat); else n_pass++;
            end
        end
        n_checks++; if (n_valid != 17) $display("FAIL stream_count got=%0d exp=17", n_valid); else n_pass++;
        n_checks++; if (n_done != 2) $display("FAIL stream_dones got=%0d exp=2", n_done); else n_pass++;
    endtask

    task automatic test_gaps();
        bit pat [8] = '{1, 0, 1, 1, 0, 1, 0, 0};
        int k = 0;
        drive_cycle(1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            randomize_row();
            drive_cycle(pat[c], 1'b0);
            n_checks++;
            if (valid_out !== (c >= 1 && pat[c-1]))
                $display("FAIL gap_valid cyc=%0d got=%b exp=%b", c, valid_out, (c >= 1 && pat[c-1]));
            else n_pass++;
            if (c >= 1 && pat[c-1]) begin
                n_checks++; if (row_index !== RW'(k)) $display("FAIL gap_row cyc=%0d got=%0d exp=%0d", c, row_index, k); else n_pass++;
                n_checks++; if (out_bus !== exp_bus) $display("FAIL gap_out cyc=%0d got=%h exp=%h", c, out_bus, exp_bus); else n_pass++;
                k++;
            end
        end
        n_checks++; if (k != 4) $display("FAIL gap_count got=%0d exp=4", k); else n_pass++;
    endtask

    task automatic test_flush();
        drive_cycle(1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            randomize_row();
            drive_cycle(1'b1, 1'b0);
        end
        randomize_row();
        drive_cycle(1'b1, 1'b1);
        n_checks++; if (valid_out !== 1'b1) $display("FAIL flush_inflight_valid got=%b exp=1", valid_out); else n_pass++;
        n_checks++; if (row_index !== 3'd2) $display("FAIL flush_inflight_row got=%0d exp=2", row_index); else n_pass++;
        n_checks++; if (out_bus !== exp_bus) $display("FAIL flush_inflight_out got=%h exp=%h", out_bus, exp_bus); else n_pass++;
        drive_cycle(1'b0, 1'b0);
        n_checks++; if (valid_out !== 1'b0) $display("FAIL flush_dropped_valid got=%b exp=0", valid_out); else n_pass++;
        for (int c = 0; c < 9; c++) begin
            randomize_row();
            drive_cycle(c < 8, 1'b0);
            n_checks++;
            if (valid_out !== (c >= 1)) $display("FAIL flush_after_valid cyc=%0d got=%b exp=%b", c, valid_out, (c >= 1));
            else n_pass++;
            if (c >= 1) begin
                n_checks++; if (row_index !== RW'(c - 1)) $display("FAIL flush_after_row cyc=%0d got=%0d exp=%0d", c, row_index, c - 1); else n_pass++;
                n_checks++; if (block_done !== (c == 8)) $display("FAIL flush_after_done cyc=%0d got=%b exp=%b", c, block_done, (c == 8)); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        bit en, fl;
        for (int c = 0; c < 300; c++) begin
            if (c == 150) begin
                // Mid-block asynchronous reset, away from the clock edge.
                reset = 1'b1;
                #2;
                n_checks++; if (valid_out !== 1'b0 || out_bus !== 64'd0) $display("FAIL rand_midreset got=%b/%h exp=0/0", valid_out, out_bus); else n_pass++;
                reset = 1'b0;
                model_reset();
            end
            randomize_row();
            en = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 15) == 0);
            drive_cycle(en, fl);
            n_checks++; if (valid_out !== exp_valid) $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, valid_out, exp_valid); else n_pass++;
            n_checks++; if (block_done !== exp_done) $display("FAIL rand_done cyc=%0d got=%b exp=%b", c, block_done, exp_done); else n_pass++;
            n_checks++; if (row_index !== exp_idx) $display("FAIL rand_row cyc=%0d got=%0d exp=%0d", c, row_index, exp_idx); else n_pass++;
            n_checks++; if (sat_out !== exp_sat) $display("FAIL rand_sat cyc=%0d got=%h exp=%h", c, sat_out, exp_sat); else n_pass++;
            n_checks++; if (out_bus !== exp_bus) $display("FAIL rand_out cyc=%0d got=%h exp=%h", c, out_bus, exp_bus); else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_add();
        test_clipping();
        test_streaming();
        test_gaps();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
